// File: rtl/usb_speed_detect.sv
// USB speed detector: filtered linestate drives an attach / bus-reset / chirp FSM to classify LS, FS or HS.
// O_speed/O_done are registered and update on the edge that enters DONE; there is no flow control.
module usb_speed_detect #(
  parameter int pCOUNTER_WIDTH = 24,
  parameter int pCHIRP_PAIRS   = 3,
  parameter int pDEBOUNCE      = 0
) (
  input  logic                      fe_clk,
  input  logic                      reset_i,
  input  logic [1:0]                fe_linestate,
  input  logic                      I_restart,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait0,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait1,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait2,
  input  logic                      I_force_en,
  input  logic [1:0]                I_force_speed,
  output logic [1:0]                O_speed,
  output logic                      O_done,
  output logic [2:0]                O_state
);

  localparam logic [1:0] USB_SPEED_AUTO = 2'd0;
  localparam logic [1:0] USB_SPEED_LS   = 2'd1;
  localparam logic [1:0] USB_SPEED_FS   = 2'd2;
  localparam logic [1:0] USB_SPEED_HS   = 2'd3;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

  localparam int CHW = $clog2(pCHIRP_PAIRS + 1) + 1;
  localparam logic [CHW-1:0] CHIRP_LAST = (pCHIRP_PAIRS > 0) ? CHW'(pCHIRP_PAIRS - 1) : '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACH  = 3'd1,
    HIGH_LS = 3'd2,
    HIGH_FS = 3'd3,
    LOW     = 3'd4,
    CHIRP   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [pCOUNTER_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CHW-1:0]            chirp_q, chirp_d;
  logic [1:0]                ls, ls_prev_q, speed_set, speed_d;
  logic                      done_d, force_q, abort;

  generate
    if (pDEBOUNCE == 0) begin : g_no_debounce
      assign ls = fe_linestate;
    end else begin : g_debounce
      // run_q counts consecutive cycles the raw value has matched cand_q, saturating at the accept length
      localparam int RW = $clog2(pDEBOUNCE + 2);
      localparam logic [RW-1:0] RUN_ACCEPT = RW'(pDEBOUNCE + 1);
      logic [1:0]    cand_q, ls_q;
      logic [RW-1:0] run_q, run_d;

      always_comb begin
        run_d = RW'(1);
        if (fe_linestate == cand_q)
          run_d = (run_q == RUN_ACCEPT) ? RUN_ACCEPT : run_q + RW'(1);
      end

      always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
          cand_q <= LS_SE0;
          run_q  <= '0;
          ls_q   <= LS_SE0;
        end else begin
          cand_q <= fe_linestate;
          run_q  <= run_d;
          if (run_d == RUN_ACCEPT)
            ls_q <= fe_linestate;
        end
      end

      assign ls = ls_q;
    end
  endgenerate

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + pCOUNTER_WIDTH'(1);
  assign abort   = I_restart | (force_q & ~I_force_en);

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      chirp_q   <= '0;
      ls_prev_q <= LS_SE0;
      force_q   <= 1'b0;
      O_speed   <= USB_SPEED_AUTO;
      O_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      chirp_q   <= chirp_d;
      ls_prev_q <= ls;
      force_q   <= I_force_en;
      O_speed   <= speed_d;
      O_done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chirp_d   = chirp_q;
    speed_set = USB_SPEED_AUTO;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      chirp_d = '0;
    end else if (!I_force_en) begin
      case (state_q)
        IDLE: begin
          if (ls != LS_SE0)            cnt_d   = '0;
          else if (cnt_q >= I_wait0)   state_d = ATTACH;
          else                         cnt_d   = cnt_inc;
        end
        ATTACH: begin
          if (ls == LS_K)      state_d = HIGH_LS;
          else if (ls == LS_J) state_d = HIGH_FS;
        end
        HIGH_LS: begin
          if (ls == LS_K) cnt_d = cnt_inc;
          else if (ls == LS_SE0 && cnt_q >= I_wait1) begin
            state_d   = DONE;
            speed_set = USB_SPEED_LS;
          end else state_d = IDLE;
        end
        HIGH_FS: begin
          if (ls == LS_J) cnt_d = cnt_inc;
          else if (ls == LS_SE0 && cnt_q >= I_wait1) state_d = LOW;
          else state_d = IDLE;
        end
        LOW: begin
          if (cnt_q >= I_wait2)  state_d = CHIRP;
          else if (ls == LS_SE0) cnt_d   = cnt_inc;
          else begin
            state_d   = DONE;
            speed_set = USB_SPEED_FS;
          end
        end
        CHIRP: begin
          if (pCHIRP_PAIRS == 0 && ls != LS_SE0) begin
            state_d   = DONE;
            speed_set = USB_SPEED_HS;
          end else if (ls_prev_q == LS_K && ls == LS_J) begin
            if (chirp_q >= CHIRP_LAST) begin
              state_d   = DONE;
              speed_set = USB_SPEED_HS;
            end else begin
              chirp_d = chirp_q + CHW'(1);
              cnt_d   = '0;
            end
          end else if (ls == ls_prev_q) begin
            // a stalled bus during chirp means the host never answered: fall back to FS
            if (cnt_q >= I_wait2) begin
              state_d   = DONE;
              speed_set = USB_SPEED_FS;
            end else cnt_d = cnt_inc;
          end else cnt_d = '0;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
        cnt_d   = '0;
        chirp_d = '0;
      end
    end
  end

  always_comb begin
    speed_d = O_speed;
    done_d  = O_done;
    if (abort) begin
      speed_d = USB_SPEED_AUTO;
      done_d  = 1'b0;
    end else if (I_force_en) begin
      speed_d = I_force_speed;
      done_d  = 1'b1;
    end else if (state_d == DONE && state_q != DONE) begin
      speed_d = speed_set;
      done_d  = 1'b1;
    end
  end

  assign O_state = state_q;

endmodule

// File: tb/tb_usb_speed_detect.sv
// Bench for usb_speed_detect: directed attach/reset/chirp/force scenarios plus randomized
// linestate sequences scored against an outcome model built from run lengths and thresholds.
`timescale 1ns/1ps
module tb_usb_speed_detect;
  localparam int CW = 24;
  localparam int P  = 3;
  localparam logic [1:0] AUTO = 2'd0, LS = 2'd1, FS = 2'd2, HS = 2'd3;
  localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10;

  logic          fe_clk;
  logic          reset_i;
  logic [1:0]    fe_linestate;
  logic          restart;
  logic [CW-1:0] wait0, wait1, wait2;
  logic          force_en;
  logic [1:0]    force_speed;
  logic [1:0]    speed;
  logic          done;
  logic [2:0]    state;
  logic [1:0]    db_linestate;
  logic          db_restart;
  logic [1:0]    db_speed;
  logic          db_done;
  logic [2:0]    db_state;
  int checks = 0;
  int errors = 0;

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  usb_speed_detect #(.pCOUNTER_WIDTH(CW), .pCHIRP_PAIRS(P), .pDEBOUNCE(0)) dut (
    .fe_clk(fe_clk), .reset_i(reset_i), .fe_linestate(fe_linestate), .I_restart(restart),
    .I_wait0(wait0), .I_wait1(wait1), .I_wait2(wait2),
    .I_force_en(force_en), .I_force_speed(force_speed),
    .O_speed(speed), .O_done(done), .O_state(state));

  usb_speed_detect #(.pCOUNTER_WIDTH(CW), .pCHIRP_PAIRS(P), .pDEBOUNCE(2)) dut_db (
    .fe_clk(fe_clk), .reset_i(reset_i), .fe_linestate(db_linestate), .I_restart(db_restart),
    .I_wait0(CW'(8)), .I_wait1(CW'(32)), .I_wait2(CW'(32)),
    .I_force_en(1'b0), .I_force_speed(2'b00),
    .O_speed(db_speed), .O_done(db_done), .O_state(db_state));

  task automatic drive(input logic [1:0] v, input int n);
    fe_linestate = v;
    repeat (n) @(posedge fe_clk);
    #1;
  endtask

  task automatic drive_db(input logic [1:0] v, input int n);
    db_linestate = v;
    repeat (n) @(posedge fe_clk);
    #1;
  endtask

  task automatic do_restart();
    fe_linestate = SE0;
    restart = 1'b1;
    @(posedge fe_clk); #1;
    restart = 1'b0;
  endtask

  task automatic spec_waits();
    wait0 = CW'(8); wait1 = CW'(32); wait2 = CW'(32);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge fe_clk); #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (speed !== AUTO || done !== 1'b0) begin errors++; $display("FAIL reset_outputs: got speed=%0d done=%0d want 0/0", speed, done); end
    checks++; if (db_state !== 3'd0 || db_done !== 1'b0 || db_speed !== AUTO) begin errors++; $display("FAIL reset_db: got state=%0d done=%0d speed=%0d want 0/0/0", db_state, db_done, db_speed); end
    reset_i = 1'b0;
  endtask

  task automatic test_short_k();
    spec_waits(); do_restart();
    drive(SE0, 10); drive(K, 10); drive(SE0, 1);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL short_k_state: got %0d want 0", state); end
    checks++; if (speed !== AUTO || done !== 1'b0) begin errors++; $display("FAIL short_k_out: got speed=%0d done=%0d want 0/0", speed, done); end
  endtask

  task automatic test_ls_detect();
    spec_waits(); do_restart();
    drive(SE0, 10); drive(K, 34); drive(SE0, 2);
    checks++; if (speed !== LS || done !== 1'b1) begin errors++; $display("FAIL ls_detect: got speed=%0d done=%0d want 1/1", speed, done); end
    checks++; if (state !== 3'd6) begin errors++; $display("FAIL ls_state: got %0d want 6", state); end
  endtask

  task automatic test_fs_detect();
    spec_waits(); do_restart();
    drive(SE0, 10); drive(J, 34); drive(SE0, 31); drive(J, 1);
    checks++; if (speed !== FS || done !== 1'b1) begin errors++; $display("FAIL fs_detect: got speed=%0d done=%0d want 2/1", speed, done); end
    drive(K, 5);
    checks++; if (speed !== FS || state !== 3'd6) begin errors++; $display("FAIL fs_hold: got speed=%0d state=%0d want 2/6", speed, state); end
  endtask

  task automatic test_hs_detect();
    spec_waits(); do_restart();
    drive(SE0, 10); drive(J, 34); drive(SE0, 34);
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL chirp_entry: got state %0d want 5", state); end
    for (int i = 0; i < 3; i++) begin
      drive(K, 4); drive(J, 4);
    end
    checks++; if (speed !== HS || done !== 1'b1) begin errors++; $display("FAIL hs_detect: got speed=%0d done=%0d want 3/1", speed, done); end
    do_restart();
    drive(SE0, 10); drive(J, 34); drive(SE0, 34); drive(J, 40);
    checks++; if (speed !== FS || done !== 1'b1) begin errors++; $display("FAIL chirp_timeout: got speed=%0d done=%0d want 2/1", speed, done); end
  endtask

  task automatic test_threshold_change();
    do_restart();
    wait0 = CW'(100); wait1 = CW'(32); wait2 = CW'(32);
    drive(SE0, 10);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL thr_before: got state %0d want 0", state); end
    wait0 = CW'(5);
    drive(SE0, 1);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL thr_after: got state %0d want 1", state); end
  endtask

  task automatic test_force();
    spec_waits(); do_restart();
    drive(SE0, 10); drive(J, 5);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL force_pre: got state %0d want 3", state); end
    force_en = 1'b1; force_speed = HS;
    drive(J, 1);
    checks++; if (speed !== HS || done !== 1'b1 || state !== 3'd3) begin errors++; $display("FAIL force_apply: got speed=%0d done=%0d state=%0d want 3/1/3", speed, done, state); end
    restart = 1'b1;
    drive(J, 1);
    checks++; if (speed !== AUTO || done !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL restart_wins: got speed=%0d done=%0d state=%0d want 0/0/0", speed, done, state); end
    restart = 1'b0;
    force_speed = LS;
    drive(J, 1);
    checks++; if (speed !== LS || done !== 1'b1) begin errors++; $display("FAIL force_reapply: got speed=%0d done=%0d want 1/1", speed, done); end
    force_en = 1'b0;
    drive(J, 1);
    checks++; if (speed !== AUTO || done !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL force_fall: got speed=%0d done=%0d state=%0d want 0/0/0", speed, done, state); end
  endtask

  task automatic test_async_reset();
    spec_waits(); do_restart();
    drive(SE0, 10); drive(J, 34); drive(SE0, 10);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL low_pre: got state %0d want 4", state); end
    #3 reset_i = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || speed !== AUTO || done !== 1'b0) begin errors++; $display("FAIL async_low: got state=%0d speed=%0d done=%0d want 0/0/0", state, speed, done); end
    @(posedge fe_clk); #1 reset_i = 1'b0;
    do_restart();
    drive(SE0, 10); drive(K, 34); drive(SE0, 1);
    checks++; if (speed !== LS) begin errors++; $display("FAIL done_pre: got speed %0d want 1", speed); end
    #3 reset_i = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || speed !== AUTO || done !== 1'b0) begin errors++; $display("FAIL async_done: got state=%0d speed=%0d done=%0d want 0/0/0", state, speed, done); end
    @(posedge fe_clk); #1 reset_i = 1'b0;
  endtask

  task automatic test_debounce();
    db_linestate = SE0; db_restart = 1'b1;
    @(posedge fe_clk); #1 db_restart = 1'b0;
    drive_db(SE0, 14);
    checks++; if (db_state !== 3'd1) begin errors++; $display("FAIL db_attach: got state %0d want 1", db_state); end
    drive_db(K, 2); drive_db(SE0, 4);
    checks++; if (db_state !== 3'd1) begin errors++; $display("FAIL db_glitch: got state %0d want 1", db_state); end
    drive_db(J, 6);
    checks++; if (db_state !== 3'd3) begin errors++; $display("FAIL db_j_accept: got state %0d want 3", db_state); end
    db_linestate = SE0; db_restart = 1'b1;
    @(posedge fe_clk); #1 db_restart = 1'b0;
    drive_db(SE0, 14); drive_db(K, 5);
    checks++; if (db_state !== 3'd2) begin errors++; $display("FAIL db_k_accept: got state %0d want 2", db_state); end
  endtask

  // Outcome model: a state's threshold w needs w+1 qualifying cycles; a state entered on a
  // segment's first cycle sees only the rest of that segment.
  task automatic test_random();
    int w0, w1, w2, a, b, c, n, cls;
    logic [1:0] exp_speed;
    logic exp_done;
    for (int it = 0; it < 36; it++) begin
      w0 = int'($urandom_range(10, 2));
      w1 = int'($urandom_range(12, 3));
      w2 = int'($urandom_range(14, 6));
      wait0 = CW'(w0); wait1 = CW'(w1); wait2 = CW'(w2);
      do_restart();
      cls = it % 3;
      if (cls == 0) begin
        a = int'($urandom_range(w0 + 3, w0 - 1));
        b = int'($urandom_range(w1 + 3, w1 - 1));
        drive(SE0, a); drive(K, b); drive(SE0, 1);
        exp_done  = (a >= w0 + 1) && (b >= w1 + 1);
        exp_speed = exp_done ? LS : AUTO;
        checks++; if (speed !== exp_speed || done !== exp_done) begin errors++; $display("FAIL rnd_ls it=%0d a=%0d b=%0d: got speed=%0d done=%0d want %0d/%0d", it, a, b, speed, done, exp_speed, exp_done); end
      end else if (cls == 1) begin
        a = w0 + 1 + int'($urandom_range(3, 0));
        b = int'($urandom_range(w1 + 3, w1 - 1));
        c = int'($urandom_range(w2 + 1, w2 - 2));
        drive(SE0, a); drive(J, b); drive(SE0, c); drive(J, 1);
        exp_done  = (b >= w1 + 1) && (c <= w2);
        exp_speed = exp_done ? FS : AUTO;
        checks++; if (speed !== exp_speed || done !== exp_done) begin errors++; $display("FAIL rnd_low it=%0d b=%0d c=%0d: got speed=%0d done=%0d want %0d/%0d", it, b, c, speed, done, exp_speed, exp_done); end
        drive(J, 2 * w2 + 8);
        exp_done  = (b >= w1 + 1);
        exp_speed = exp_done ? FS : AUTO;
        checks++; if (speed !== exp_speed || done !== exp_done) begin errors++; $display("FAIL rnd_fs it=%0d b=%0d c=%0d: got speed=%0d done=%0d want %0d/%0d", it, b, c, speed, done, exp_speed, exp_done); end
      end else begin
        a = w0 + 1 + int'($urandom_range(3, 0));
        b = w1 + 1 + int'($urandom_range(3, 0));
        c = int'($urandom_range(w2 + 3, w2 + 1));
        n = int'($urandom_range(4, 0));
        drive(SE0, a); drive(J, b); drive(SE0, c);
        for (int p = 0; p < n; p++) begin
          drive(K, int'($urandom_range(w2, 1)));
          drive(J, int'($urandom_range(w2, 1)));
        end
        drive(J, 2 * w2 + 8);
        exp_speed = (n >= P) ? HS : FS;
        checks++; if (speed !== exp_speed || done !== 1'b1 || state !== 3'd6) begin errors++; $display("FAIL rnd_chirp it=%0d n=%0d c=%0d: got speed=%0d done=%0d state=%0d want %0d/1/6", it, n, c, speed, done, state, exp_speed); end
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; fe_linestate = SE0; db_linestate = SE0;
    restart = 1'b0; db_restart = 1'b0; force_en = 1'b0; force_speed = AUTO;
    wait0 = CW'(8); wait1 = CW'(32); wait2 = CW'(32);
    test_reset();
    test_short_k();
    test_ls_detect();
    test_fs_detect();
    test_hs_detect();
    test_threshold_change();
    test_force();
    test_async_reset();
    test_debounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
